button_event_gen: RTL and testbench

Converts the debounced button level from the debouncer into discrete, single-cycle user-interface events: press, short click, long press and optional auto-repeat. It sits directly downstream of the debouncer and feeds the control FSMs, which consume only one-cycle pulses on CK. The debounced level is produced on a divided clock, so this block resynchronises it into the CK domain before any decision is made.

---
 rtl/botao_pkg.sv | 13 +
 rtl/sincronizador.sv | 24 ++
 rtl/button_event_gen.sv | 117 +++++++++++
 tb/tb_button_event_gen.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/botao_pkg.sv
// Shared types and helpers for the button event generator.
package botao_pkg;

    typedef enum logic [1:0] {IDLE, PRESSED, HELD} estado_t;

    // Counter wide enough to hold the larger of the two terminal counts.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchroniser for a single asynchronous level input.
module sincronizador (
    input  logic CK,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge CK or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= d;
            r_q    <= r_meta;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/button_event_gen.sv
// Turns a debounced button level into one-cycle press/short/long/repeat pulses.
// Auto-repeat is compiled in only when BUTTON_AUTO_REPEAT_EN is defined.
module button_event_gen
    import botao_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
    input  logic CK,
    input  logic rst_n,
    input  logic entrada,
    output logic pulso_press,
    output logic pulso_curto,
    output logic pulso_longo,
    output logic pulso_rep,
    output logic ativo
);

    localparam int unsigned CntW = cnt_width(LONG_CYCLES, REPEAT_CYCLES);
    localparam logic [CntW-1:0] LongLast = CntW'(LONG_CYCLES - 1);
`ifdef BUTTON_AUTO_REPEAT_EN
    localparam logic [CntW-1:0] RepLast = CntW'(REPEAT_CYCLES - 1);
`endif

    logic            w_s;
    estado_t         r_state, w_state_d;
    logic [CntW-1:0] r_cnt, w_cnt_d;
    logic            w_press, w_curto, w_longo, w_rep;
    logic            r_press, r_curto, r_longo, r_rep, r_ativo;

    sincronizador u_sync (
        .CK    (CK),
        .rst_n (rst_n),
        .d     (entrada),
        .q     (w_s)
    );

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_press   = 1'b0;
        w_curto   = 1'b0;
        w_longo   = 1'b0;
        w_rep     = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_cnt_d = '0;
                if (w_s) begin
                    w_state_d = PRESSED;
                    w_press   = 1'b1;
                end
            end
            PRESSED: begin
                // Release is checked first so it beats the terminal count.
                if (!w_s) begin
                    w_state_d = IDLE;
                    w_cnt_d   = '0;
                    w_curto   = 1'b1;
                end else if (r_cnt == LongLast) begin
                    w_state_d = HELD;
                    w_cnt_d   = '0;
                    w_longo   = 1'b1;
                end else begin
                    w_cnt_d = r_cnt + CntW'(1);
                end
            end
            HELD: begin
                if (!w_s) begin
                    w_state_d = IDLE;
                    w_cnt_d   = '0;
                end else begin
`ifdef BUTTON_AUTO_REPEAT_EN
                    if (r_cnt == RepLast) begin
                        w_cnt_d = '0;
                        w_rep   = 1'b1;
                    end else begin
                        w_cnt_d = r_cnt + CntW'(1);
                    end
`else
                    w_cnt_d = '0;
`endif
                end
            end
            default: begin
                w_state_d = IDLE;
                w_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CK or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_press <= 1'b0;
            r_curto <= 1'b0;
            r_longo <= 1'b0;
            r_rep   <= 1'b0;
            r_ativo <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_press <= w_press;
            r_curto <= w_curto;
            r_longo <= w_longo;
            r_rep   <= w_rep;
            r_ativo <= (w_state_d != IDLE);
        end
    end

    assign pulso_press = r_press;
    assign pulso_curto = r_curto;
    assign pulso_longo = r_longo;
    assign pulso_rep   = r_rep;
    assign ativo       = r_ativo;

endmodule

// File: tb/tb_button_event_gen.sv
// Randomised bench for button_event_gen against a press-duration reference model.
module tb_button_event_gen;

    localparam int unsigned L = 8;
    localparam int unsigned R = 4;
`ifdef BUTTON_AUTO_REPEAT_EN
    localparam bit RepEn = 1'b1;
`else
    localparam bit RepEn = 1'b0;
`endif

    logic CK = 1'b0;
    logic rst_n;
    logic entrada;
    logic pulso_press, pulso_curto, pulso_longo, pulso_rep, ativo;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: input delay line plus edges elapsed since the press.
    bit m_q1, m_q2, m_active;
    int m_d;
    bit m_press, m_curto, m_longo, m_rep, m_ativo;

    button_event_gen #(
        .LONG_CYCLES   (L),
        .REPEAT_CYCLES (R)
    ) dut (
        .CK          (CK),
        .rst_n       (rst_n),
        .entrada     (entrada),
        .pulso_press (pulso_press),
        .pulso_curto (pulso_curto),
        .pulso_longo (pulso_longo),
        .pulso_rep   (pulso_rep),
        .ativo       (ativo)
    );

    always #5 CK = ~CK;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q1 = 0; m_q2 = 0; m_active = 0; m_d = 0;
        m_press = 0; m_curto = 0; m_longo = 0; m_rep = 0; m_ativo = 0;
    endtask

    task automatic model_edge(input bit ent);
        bit s;
        if (!rst_n) begin
            model_reset();
            return;
        end
        s = m_q2;
        m_press = 0; m_curto = 0; m_longo = 0; m_rep = 0;
        if (!m_active) begin
            if (s) begin
                m_active = 1;
                m_d      = 0;
                m_press  = 1;
            end
        end else begin
            m_d++;
            if (!s) begin
                m_active = 0;
                if (m_d <= int'(L)) m_curto = 1;
            end else if (m_d == int'(L)) begin
                m_longo = 1;
            end else if (m_d > int'(L) && ((m_d - int'(L)) % int'(R)) == 0) begin
                m_rep = RepEn;
            end
        end
        m_q2    = m_q1;
        m_q1    = ent;
        m_ativo = m_active;
    endtask

    task automatic compare_all();
        check_eq("press", int'(pulso_press), int'(m_press));
        check_eq("curto", int'(pulso_curto), int'(m_curto));
        check_eq("longo", int'(pulso_longo), int'(m_longo));
        check_eq("rep",   int'(pulso_rep),   int'(m_rep));
        check_eq("ativo", int'(ativo),       int'(m_ativo));
    endtask

    task automatic step(input logic ent);
        @(negedge CK);
        entrada = ent;
        @(posedge CK);
        model_edge(ent);
        #1;
        compare_all();
    endtask

    task automatic steps(input logic ent, input int n);
        for (int i = 0; i < n; i++) step(ent);
    endtask

    // Async reset away from the edge; outputs must clear without waiting for CK.
    task automatic async_reset_check();
        @(posedge CK);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
    endtask

    initial begin
        int hi, lo;
        rst_n   = 1'b0;
        entrada = 1'b1;
        model_reset();

        // Reset held with the button pressed: everything stays quiet.
        #2;
        compare_all();
        steps(1'b1, 2);
        rst_n = 1'b1;
        steps(1'b1, 2);
        check_eq("no_press_before_3rd_edge", int'(pulso_press), 0);
        step(1'b1);
        check_eq("press_on_3rd_edge", int'(pulso_press), 1);
        check_eq("ativo_with_press", int'(ativo), 1);

        // Long hold through repeats, then release.
        steps(1'b1, 30);
        steps(1'b0, 6);
        check_eq("ativo_idle_after_hold", int'(ativo), 0);

        // Short press.
        steps(1'b1, 5);
        steps(1'b0, 6);

        // Release landing on and around the terminal count.
        for (int n = L - 1; n <= int'(L) + 1; n++) begin
            steps(1'b1, n);
            steps(1'b0, 6);
        end

        // Reset while in HELD, button still down afterwards.
        steps(1'b1, 15);
        async_reset_check();
        steps(1'b1, 2);
        rst_n = 1'b1;
        steps(1'b1, 2);
        check_eq("rearm_no_early_press", int'(pulso_press), 0);
        step(1'b1);
        check_eq("rearm_press", int'(pulso_press), 1);
        steps(1'b1, 4);
        steps(1'b0, 6);

        // Random bursts of holds and gaps.
        for (int b = 0; b < 120; b++) begin
            hi = (($urandom % 4) == 0) ? 1 + ($urandom % 3) : 1 + ($urandom % 35);
            lo = 1 + ($urandom % 8);
            steps(1'b1, hi);
            steps(1'b0, lo);
            if (b == 60) begin
                steps(1'b1, 12);
                async_reset_check();
                step(1'b1);
                rst_n = 1'b1;
            end
        end
        steps(1'b0, 6);
        check_eq("final_idle", int'(ativo), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
